// File: rtl/uop_issue_queue.sv
// Operand-formation queue between decode and execute: picks operand B,
// derives the shift amount and buffers micro-ops in a small FWFT FIFO.
package uop_pkg;
    typedef enum logic [3:0] {
        OP_NOP,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SLL,
        OP_SRL,
        OP_SRA,
        OP_SLT,
        OP_SLTU
    } op_t;
endpackage

module uop_issue_queue
    import uop_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  op_t                        in_op,
    input  logic [W-1:0]               in_a,
    input  logic [W-1:0]               in_b,
    input  logic [W-1:0]               in_imm,
    input  logic                       in_use_imm,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output op_t                        out_op,
    output logic [W-1:0]               out_a,
    output logic [W-1:0]               out_b,
    output logic [$clog2(W)-1:0]       out_shamt,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int SW = $clog2(W);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    op_t              op_q    [DEPTH];
    op_t              op_d    [DEPTH];
    logic [W-1:0]     a_q     [DEPTH];
    logic [W-1:0]     a_d     [DEPTH];
    logic [W-1:0]     b_q     [DEPTH];
    logic [W-1:0]     b_d     [DEPTH];
    logic [SW-1:0]    shamt_q [DEPTH];
    logic [SW-1:0]    shamt_d [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];
    logic [TAG_W-1:0] tag_d   [DEPTH];

    logic [W-1:0]  b_sel;
    logic [SW-1:0] shamt_sel;
    logic          push;
    logic          pop;

    always_comb begin
        b_sel     = in_use_imm ? in_imm : in_b;
        shamt_sel = b_sel[SW-1:0];
        in_ready  = ~rst & ~flush & (count_q < FULL);
        out_valid = (count_q != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        shamt_d  = shamt_q;
        tag_d    = tag_q;
        // Flush only rewinds bookkeeping; stale storage is never visible
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                op_d[wr_ptr_q]    = in_op;
                a_d[wr_ptr_q]     = in_a;
                b_d[wr_ptr_q]     = b_sel;
                shamt_d[wr_ptr_q] = shamt_sel;
                tag_d[wr_ptr_q]   = in_tag;
                wr_ptr_d          = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]    <= OP_NOP;
                a_q[i]     <= '0;
                b_q[i]     <= '0;
                shamt_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shamt_q  <= shamt_d;
            tag_q    <= tag_d;
        end
    end

    assign out_op    = op_q[rd_ptr_q];
    assign out_a     = a_q[rd_ptr_q];
    assign out_b     = b_q[rd_ptr_q];
    assign out_shamt = shamt_q[rd_ptr_q];
    assign out_tag   = tag_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: tb/tb_uop_issue_queue.sv
// Bench for uop_issue_queue: directed plan steps followed by random
// traffic, all compared against a queue-based reference model.
module tb_uop_issue_queue;
    import uop_pkg::*;

    localparam int W     = 64;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    op_t              in_op;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [W-1:0]     in_imm;
    logic             in_use_imm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    op_t              out_op;
    logic [W-1:0]     out_a;
    logic [W-1:0]     out_b;
    logic [5:0]       out_shamt;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       count;

    uop_issue_queue #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_shamt  (out_shamt),
        .out_tag    (out_tag),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        op_t         op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] sh;
        logic [63:0] tag;
    } ent_t;

    ent_t q[$];
    bit   after_rst;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return !rst && !flush && (q.size() < DEPTH);
    endfunction

    function automatic ent_t mk();
        ent_t e;
        logic [63:0] bs;
        bs    = in_use_imm ? in_imm : in_b;
        e.op  = in_op;
        e.a   = in_a;
        e.b   = bs;
        e.sh  = bs % 64;
        e.tag = 64'(in_tag);
        return e;
    endfunction

    task automatic check_outs();
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("count", 64'(count), 64'(q.size()));
        if (q.size() != 0) begin
            chk("out_op", 64'(out_op), 64'(q[0].op));
            chk("out_a", out_a, q[0].a);
            chk("out_b", out_b, q[0].b);
            chk("out_shamt", 64'(out_shamt), q[0].sh);
            chk("out_tag", 64'(out_tag), q[0].tag);
        end else if (after_rst) begin
            chk("rst_op", 64'(out_op), 64'(OP_NOP));
            chk("rst_a", out_a, 64'd0);
            chk("rst_b", out_b, 64'd0);
            chk("rst_sh", 64'(out_shamt), 64'd0);
            chk("rst_tag", 64'(out_tag), 64'd0);
        end
    endtask

    // Inputs are set at the falling edge before calling this.
    task automatic cyc();
        bit   m_push, m_pop;
        ent_t e;
        #1;
        chk("in_ready", 64'(in_ready), 64'(model_ready()));
        m_push = in_valid && model_ready();
        m_pop  = (q.size() != 0) && out_ready && !flush && !rst;
        e      = mk();
        @(posedge clk);
        if (rst) begin
            q.delete();
            after_rst = 1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back(e);
                after_rst = 0;
            end
        end
        @(negedge clk);
        check_outs();
    endtask

    task automatic drive(input bit v, input op_t op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] imm,
                         input bit ui, input logic [3:0] tag);
        in_valid   = v;
        in_op      = op;
        in_a       = a;
        in_b       = b;
        in_imm     = imm;
        in_use_imm = ui;
        in_tag     = tag;
    endtask

    initial begin
        rst = 1; flush = 0; out_ready = 0;
        drive(0, OP_NOP, 0, 0, 0, 0, 0);
        @(negedge clk);
        cyc();
        cyc();
        rst = 0;
        cyc();
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Plan 1: single push, payload held, then popped
        drive(1, OP_ADD, 64'h10, 64'h22, 64'h0, 0, 4'd3);
        cyc();
        drive(0, OP_NOP, 0, 0, 0, 0, 0);
        chk("p1_out_b", out_b, 64'h22);
        chk("p1_shamt", 64'(out_shamt), 64'h22);
        chk("p1_count", 64'(count), 64'd1);
        repeat (5) cyc();
        chk("p1_held_tag", 64'(out_tag), 64'd3);
        out_ready = 1;
        cyc();
        chk("p1_drained", 64'(count), 64'd0);
        out_ready = 0;

        // Plan 2: immediate selection and shift amount truncation
        drive(1, OP_SLL, 64'h1, 64'h5, 64'h147, 1, 4'd1);
        cyc();
        drive(0, OP_NOP, 0, 0, 0, 0, 0);
        chk("p2_out_b", out_b, 64'h147);
        chk("p2_shamt", 64'(out_shamt), 64'h07);
        out_ready = 1;
        cyc();
        out_ready = 0;

        // Plan 3: fill, blocked 5th push, one pop lets it in
        for (int i = 0; i < 4; i++) begin
            drive(1, OP_XOR, 64'(i), 64'(i * 3), 0, 0, 4'(i));
            cyc();
        end
        drive(1, OP_XOR, 64'd4, 64'd12, 0, 0, 4'd4);
        chk("p3_full_count", 64'(count), 64'd4);
        chk("p3_full_ready", 64'(in_ready), 64'd0);
        cyc();
        chk("p3_held_count", 64'(count), 64'd4);
        out_ready = 1;
        cyc();
        out_ready = 0;
        chk("p3_after_pop", 64'(count), 64'd3);
        chk("p3_ready_back", 64'(in_ready), 64'd1);
        cyc();
        drive(0, OP_NOP, 0, 0, 0, 0, 0);
        out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            chk("p3_order", 64'(out_tag), 64'(i));
            cyc();
        end
        chk("p3_empty", 64'(out_valid), 64'd0);

        // Plan 4: streaming through pointer wrap
        for (int i = 0; i < 20; i++) begin
            drive(1, OP_ADD, 64'(i), 64'(i + 100), 0, 0, 4'(i % 16));
            cyc();
            chk("p4_count", 64'(count), 64'd1);
            chk("p4_tag", 64'(out_tag), 64'(i % 16));
        end
        drive(0, OP_NOP, 0, 0, 0, 0, 0);
        cyc();
        out_ready = 0;

        // Plan 5: flush beats concurrent push and pop
        for (int i = 0; i < 3; i++) begin
            drive(1, OP_OR, 64'(i), 64'(i), 0, 0, 4'(i + 5));
            cyc();
        end
        flush = 1;
        out_ready = 1;
        drive(1, OP_OR, 64'hff, 64'hff, 0, 0, 4'd8);
        cyc();
        flush = 0;
        out_ready = 0;
        chk("p5_count", 64'(count), 64'd0);
        chk("p5_valid", 64'(out_valid), 64'd0);
        drive(1, OP_AND, 64'h9, 64'h9, 0, 0, 4'd9);
        cyc();
        drive(0, OP_NOP, 0, 0, 0, 0, 0);
        chk("p5_alone_cnt", 64'(count), 64'd1);
        chk("p5_alone_tag", 64'(out_tag), 64'd9);
        out_ready = 1;
        cyc();
        out_ready = 0;

        // Plan 6: reset mid-traffic
        for (int i = 0; i < 2; i++) begin
            drive(1, OP_SUB, 64'habc, 64'h3, 0, 0, 4'(i));
            cyc();
        end
        drive(0, OP_NOP, 0, 0, 0, 0, 0);
        rst = 1;
        #1;
        chk("p6_ready_rst", 64'(in_ready), 64'd0);
        cyc();
        rst = 0;
        chk("p6_count", 64'(count), 64'd0);
        chk("p6_op", 64'(out_op), 64'(OP_NOP));
        chk("p6_a", out_a, 64'd0);
        #1;
        chk("p6_ready_after", 64'(in_ready), 64'd1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 59) == 0);
            flush      = ($urandom_range(0, 24) == 0);
            out_ready  = $urandom_range(0, 2) != 0;
            drive($urandom_range(0, 2) != 0,
                  op_t'($urandom_range(0, 10)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, 1'($urandom), 4'($urandom));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uop_issue_queue.md
Name: uop_issue_queue

Overview:
Operand-formation and buffering stage directly upstream of the per-op execution unit. It accepts decoded micro-ops, selects register or immediate operand B, and derives the shift amount. It then queues entries in a small FIFO and presents the head entry to the execute stage (a, b, shamt, op) under a valid/ready handshake. This decouples decode stalls from execute back-pressure.

Parameters:
W, 64, datapath width; must match the execute stage W.
DEPTH, 4, queue entries; power of two, >= 2.
TAG_W, 4, width of the opaque tag carried with each micro-op.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
flush  in  1  discard all queued entries.
in_valid  in  1  upstream micro-op valid.
in_ready  out  1  queue can accept.
in_op  in  uop_pkg::op_t  micro-op code.
in_a  in  W  operand A.
in_b  in  W  register operand B.
in_imm  in  W  immediate (already sign/zero-extended by decode).
in_use_imm  in  1  1 = B comes from in_imm.
in_tag  in  TAG_W  opaque tag.
out_valid  out  1  head entry valid.
out_ready  in  1  execute stage accepts.
out_op  out  uop_pkg::op_t  head op.
out_a  out  W  head operand A.
out_b  out  W  head operand B.
out_shamt  out  $clog2(W)  head shift amount.
out_tag  out  TAG_W  head tag.
count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset:
  - wr_ptr, rd_ptr and count go to 0; out_valid = 0.
  - All storage entries clear to zero with op = uop_pkg::OP_NOP, so out_op = OP_NOP and out_a/out_b/out_shamt/out_tag = 0.
  - Reset mid-traffic drops every entry; in_ready is 0 while rst is high.
- Operand formation, combinational at enqueue:
  - b_sel = in_use_imm ? in_imm : in_b.
  - shamt = b_sel[$clog2(W)-1:0], i.e. b_sel mod W; upper bits are ignored.
  - The stored entry is {in_op, in_a, b_sel, shamt, in_tag}.
- Handshakes:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
  - in_ready = ~rst & ~flush & (count < DEPTH). There is no same-cycle pass-through at full.
  - out_valid = (count != 0). Out payload is read combinationally from storage[rd_ptr] (first-word-fall-through).
  - Latency: an entry pushed in cycle N is visible on out_* in cycle N+1 at the earliest.
- Pointers:
  - Width is $clog2(DEPTH); pointers wrap modulo DEPTH with no skipped slot.
  - count is tracked separately. push only: +1. pop only: -1. Both: unchanged, with both pointers advancing.
- Boundaries:
  - Full (count = DEPTH): in_ready = 0. A pop that cycle brings count to DEPTH-1, and in_ready rises the next cycle.
  - Empty: out_valid = 0. out_ready is ignored; pointers and count do not move.
  - Payload stability: while out_valid = 1 and out_ready = 0, out_* holds constant, barring flush or rst.
  - Flush has priority over push and pop in the same cycle. The next cycle has count = 0, both pointers = 0 and out_valid = 0. Storage contents are not cleared.
  - rst has priority over flush.
  - in_valid with in_ready = 0 causes no state change; upstream must hold its payload.

Test Plan:
1. Push 1 entry {OP_ADD, a=0x10, b=0x22, use_imm=0, tag=3}, out_ready=0 -> next cycle out_valid=1, out_b=0x22, out_shamt=0x22, count=1; payload holds 5 cycles until out_ready=1, then count=0.
2. use_imm=1, imm=0x0000_0000_0000_0147, b=0x5 -> out_b=0x147, out_shamt=0x07 (W=64).
3. Push 4 entries with tags 0..3, out_ready=0 -> count=4, in_ready=0; a 5th push is held. Assert out_ready for one cycle -> tag 0 pops, in_ready=1 next cycle, 5th entry (tag 4) accepted. Drain order is 1,2,3,4.
4. Steady streaming with in_valid=out_ready=1 for 20 cycles (tags 0..19 mod 16) -> count stays 1 after the first cycle, tags exit in order, and pointers wrap correctly past index 3.
5. Fill 3 entries, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, nothing pushed or popped. A following push of tag 9 appears alone.
6. Fill 2 entries, assert rst for 1 cycle -> count=0, out_valid=0, out_op=OP_NOP, out_a=0. in_ready=0 during rst and 1 the cycle after.
